// File: rtl/uart_pkg.sv
// Shared UART definitions: line-control bytes, byte-transmitter state type, nibble-to-ASCII helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // 0-9 -> '0'-'9' (0x30-0x39), 10-15 -> 'A'-'F' (0x41-0x46)
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Serializes one byte as an 8N1 frame, LSB first, each bit held CLKS_PER_BIT cycles.
// Latency: line drops to the start bit on the edge that samples start while idle.
// Backpressure: start is only honoured in IDLE or in the last stop-bit cycle (flagged by done).
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load data and begin a frame (accepted when idle or while done is high)
//   data       : byte to send, sampled together with start
//   tx         : registered serial line, idle high
//   done       : high during the final cycle of the stop bit
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRELAST = CW'(CLKS_PER_BIT - 2);

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          baud_tc;

  assign baud_tc = (baud_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      baud_cnt <= baud_cnt + CW'(1);
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (start) begin
            state <= START;
            shreg <= data;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_tc) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
        STOP: begin
          // Raise done one cycle early so the sequencer can chain the next
          // byte straight into a start bit with no idle gap.
          if (baud_cnt == PRELAST) done <= 1'b1;
          if (baud_tc) begin
            baud_cnt <= '0;
            if (start) begin
              state <= START;
              shreg <= data;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/led_uart_reporter.sv
// Reports every change of the LED nibble on a UART as "<hex digit> CR LF".
// Latency: change sampled at edge N is pushed at N, popped at N+1, start bit begins at N+2.
// Backpressure: none upstream; changes arriving with the FIFO full are dropped and flagged in sticky overflow.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   led_in     : LED nibble, sampled every cycle
//   uart_tx    : serial line, idle high
//   busy       : record in flight or FIFO non-empty
//   overflow   : sticky drop indicator, cleared only by reset
module led_uart_reporter
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] led_in,
  output logic       uart_tx,
  output logic       busy,
  output logic       overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [3:0]    prev;
  logic [3:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          change;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          rec_active;
  logic          rec_active_nxt;
  logic          rec_end;
  logic          launch;
  logic [1:0]    byte_idx;
  logic [7:0]    hex_byte;
  logic          tx_start;
  logic          tx_done;
  logic [7:0]    tx_data;

  always_comb begin
    change     = (led_in != prev);
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);
    // A new record can only start once the previous one has fully ended.
    pop        = !rec_active && !fifo_empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    push       = change && (!fifo_full || pop);
    count_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);
    rec_end    = tx_done && (byte_idx == 2'd2);
    rec_active_nxt = pop ? 1'b1 : (rec_end ? 1'b0 : rec_active);
    // First byte is launched from a registered pulse; CR and LF are chained
    // off done so they follow the previous stop bit with no gap.
    tx_start   = launch || (tx_done && (byte_idx != 2'd2));
    tx_data    = !tx_done ? hex_byte : ((byte_idx == 2'd0) ? CR : LF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= 4'h0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      rec_active <= 1'b0;
      launch     <= 1'b0;
      byte_idx   <= 2'd0;
      hex_byte   <= 8'h00;
    end else begin
      launch <= 1'b0;
      if (change) prev <= led_in;
      if (change && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        hex_byte <= hex2ascii(fifo_mem[rd_ptr]);
        byte_idx <= 2'd0;
        launch   <= 1'b1;
      end else if (tx_done && (byte_idx != 2'd2)) begin
        byte_idx <= byte_idx + 2'd1;
      end
      count      <= count_nxt;
      rec_active <= rec_active_nxt;
      busy       <= rec_active_nxt || (count_nxt != '0);
    end
  end

  // Storage needs no reset: occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= led_in;
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (tx_data),
    .tx    (uart_tx),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_led_uart_reporter.sv
// Bench for led_uart_reporter at 10 clocks per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_uart_reporter;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] led_in = 4'h0;
  logic       uart_tx;
  logic       busy;
  logic       overflow;

  led_uart_reporter #(
    .CLK_HZ(1000),
    .BAUD  (100),
    .DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .led_in  (led_in),
    .uart_tx (uart_tx),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          frame_err = 0;
  logic [7:0]  rx_q[$];
  int          rx_t[$];
  logic [7:0]  exp_q[$];
  logic [3:0]  vals[6];
  string       hexd = "0123456789ABCDEF";
  int          mon_t0;
  logic [7:0]  mon_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: decodes 8N1 frames by sampling mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        mon_t0 = cyc;
        rx_t.push_back(mon_t0);
        repeat (CPB/2) @(negedge clk);
        if (uart_tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) frame_err++;
        rx_q.push_back(mon_b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_record(input logic [3:0] v);
    exp_q.push_back(hexd[v]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic flush();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    frame_err = 0;
  endtask

  task automatic compare_records(input string tag);
    check({tag, " byte count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i),
            (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    check({tag, " framing"}, frame_err, 0);
    flush();
  endtask

  task automatic wait_idle(input string tag, output int end_cyc);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    end_cyc = cyc;
    check({tag, " idle timeout"}, (n >= 4000), 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_first_start(input string tag);
    int n = 0;
    while (rx_t.size() == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " start timeout"}, (n >= 1000), 0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    led_in = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    flush();
  endtask

  task automatic new_val(input logic [3:0] avoid, output logic [3:0] o);
    do o = 4'($urandom_range(1, 15)); while (o == avoid);
  endtask

  // Six distinct non-zero nibbles in random order.
  task automatic fill_vals();
    logic [3:0] pool[15];
    logic [3:0] tmp;
    int j;
    for (int i = 0; i < 15; i++) pool[i] = 4'(i + 1);
    for (int i = 14; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = pool[i];
      pool[i] = pool[j];
      pool[j] = tmp;
    end
    for (int i = 0; i < 6; i++) vals[i] = pool[i];
  endtask

  initial begin
    int t;
    int t_end;
    int s;
    int n;
    int quiet_bad;
    logic [3:0] v;

    // Reset state and quiet line with LED held at 0
    reset  = 1'b1;
    led_in = 4'h0;
    repeat (3) @(negedge clk);
    check("reset uart_tx", uart_tx, 1);
    check("reset busy", busy, 0);
    check("reset overflow", overflow, 0);
    reset = 1'b0;
    quiet_bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
    end
    check("idle quiet cycles", quiet_bad, 0);
    check("idle no bytes", rx_q.size(), 0);

    // Single record 0x5: latency, busy rise, back-to-back bytes, length
    @(negedge clk);
    check("pre-change busy", busy, 0);
    led_in = 4'h5;
    t = cyc + 1;  // cyc value after the edge that samples the change
    @(negedge clk);
    check("busy rise", busy, 1);
    wait_idle("rec5", t_end);
    check("start latency", (rx_t.size() > 0) ? rx_t[0] - t : -1, 2);
    check("record length", (rx_t.size() > 0) ? t_end - rx_t[0] : -1, 300);
    check("cr follows hex", (rx_t.size() > 2) ? rx_t[1] - rx_t[0] : -1, 100);
    check("lf follows cr", (rx_t.size() > 2) ? rx_t[2] - rx_t[1] : -1, 100);
    add_record(4'h5);
    compare_records("rec5");

    // Random single changes
    for (int k = 0; k < 3; k++) begin
      new_val(led_in, v);
      @(negedge clk);
      led_in = v;
      wait_idle("rand single", t_end);
      add_record(v);
      compare_records($sformatf("rand single %0d", k));
    end

    // 0xA then 0xF one cycle apart
    do_reset();
    @(negedge clk);
    led_in = 4'hA;
    @(negedge clk);
    led_in = 4'hF;
    wait_idle("AF", t_end);
    check("AF overflow", overflow, 0);
    check("AF record gap", (rx_t.size() > 3) ? (rx_t[3] - rx_t[0] >= 301) : 0, 1);
    add_record(4'hA);
    add_record(4'hF);
    compare_records("AF");

    // Six changes in six cycles: first pops, four buffer, sixth drops
    do_reset();
    fill_vals();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) check("burst full no ovf", overflow, 0);
      led_in = vals[i];
    end
    @(negedge clk);
    check("burst ovf set", overflow, 1);
    wait_idle("burst", t_end);
    check("burst ovf sticky", overflow, 1);
    for (int i = 0; i < 5; i++) add_record(vals[i]);
    compare_records("burst");

    // Reset 45 cycles into a record with more entries queued
    new_val(led_in, v);
    @(negedge clk);
    led_in = v;
    wait_first_start("abort");
    s = (rx_t.size() > 0) ? rx_t[0] : cyc;
    new_val(led_in, v);
    @(negedge clk);
    led_in = v;
    new_val(led_in, v);
    @(negedge clk);
    led_in = v;
    n = 0;
    while (cyc != s + 45 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort sync timeout", (n >= 1000), 0);
    reset  = 1'b1;
    led_in = 4'h0;
    @(negedge clk);
    check("abort uart_tx", uart_tx, 1);
    check("abort busy", busy, 0);
    check("abort overflow", overflow, 0);
    reset = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 150) flush();
      if (uart_tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
    end
    check("abort fifo cleared", quiet_bad, 0);
    check("abort no bytes", rx_q.size(), 0);
    @(negedge clk);
    led_in = 4'h3;
    wait_idle("post abort", t_end);
    add_record(4'h3);
    compare_records("post abort");

    // Full FIFO, push lands on the same edge as the idle pop
    do_reset();
    fill_vals();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      led_in = vals[i];
    end
    @(negedge clk);
    check("full no ovf", overflow, 0);
    wait_first_start("pushpop");
    s = (rx_t.size() > 0) ? rx_t[0] : cyc;
    n = 0;
    while (cyc != s + 300 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("pushpop sync timeout", (n >= 1000), 0);
    led_in = vals[5];
    wait_idle("pushpop", t_end);
    check("pushpop overflow", overflow, 0);
    for (int i = 0; i < 6; i++) add_record(vals[i]);
    compare_records("pushpop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
